mcmem_bridge: RTL and testbench
===============================

# mcmem_bridge

Memory-side stage of the multicycle core. It consumes the control FSM's memory strobes (MemRead/MemWrite), the IorD-selected address and the B-register store data, and runs one valid/ready bus transaction per access. It lane-aligns stores (byte strobes) and aligns and extends loads. While an access is in flight it drives `stall` back so the control FSM and datapath write-enables hold. Load/fetch data comes out registered, for the IR/MDR capture.

## Interface
- `MAX_WAIT`, default 64: bus cycles (REQ+RESP) allowed before timeout abort.
- `clk` in 1: clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `req_read` in 1: CTL_MemRead.
- `req_write` in 1: CTL_MemWrite.
- `req_is_fetch` in 1: high when IorD=0 (instruction fetch).
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, unshifted.
- `req_funct3` in 3: instr[14:12] for loads/stores.
- `stall` out 1: control FSM and all datapath write-enables hold while high.
- `rdata` out 32: aligned/extended load or fetch word.
- `rdata_valid` out 1: one-cycle pulse in DONE for reads.
- `err_misaligned` out 1: one-cycle pulse in DONE.
- `err_timeout` out 1: one-cycle pulse in DONE.
- `bus_valid` out 1, `bus_ready` in 1: request handshake.
- `bus_we` out 1, `bus_addr` out 32 (bits[1:0]=0), `bus_wdata` out 32, `bus_wstrb` out 4.
- `bus_rsp_valid` in 1, `bus_rdata` in 32: read response.

## Operation
- States: IDLE, REQ, RESP, DONE.
- IDLE:
  - `req_read|req_write` captures addr, funct3, wdata, we, fetch flag.
  - Goes to REQ, or straight to DONE on misalign/illegal.
  - Read and write both high is illegal: no bus access, DONE with `err_misaligned`=0 and `rdata` unchanged.
- REQ: `bus_valid`=1, fields stable until `bus_ready`.
  - ready and write: DONE (posted write).
  - ready and read: RESP.
- RESP: waits for `bus_rsp_valid`, registers the aligned/extended data into `rdata`, then DONE.
- DONE: one cycle.
  - `stall`=0 and error/valid pulses are driven.
  - Requests are ignored, because they still belong to the completing access.
  - Always returns to IDLE.
- `stall` = (IDLE & (req_read|req_write)) | REQ | RESP. It is combinational, so the control holds from the first request cycle.
- Fetch forces a word, unsigned access regardless of funct3.
- Stores:
  - SB: wstrb=0001<<addr[1:0], byte replicated ×4.
  - SH: wstrb=0011<<{addr[1],1'b0}, half replicated ×2.
  - SW: 1111.
- Loads:
  - 000 LB sign, 100 LBU zero, byte lane addr[1:0].
  - 001 LH sign, 101 LHU zero, half lane addr[1].
  - 010 LW.
  - 011/110/111 are treated as LW.
- Timeout: an 8-bit counter clears on leaving IDLE and increments every REQ/RESP cycle. On reaching MAX_WAIT-1 the block drops `bus_valid`, goes to DONE, pulses `err_timeout` and sets `rdata`=0.
- `bus_rsp_valid` outside RESP is ignored.

## Timing
- Reset: state IDLE, `rdata`=0, `bus_valid`=`bus_we`=0, `bus_wstrb`=0, all pulses 0, counter 0.
- `stall`=0 during reset.
- Reset asserted mid-access drops `bus_valid` immediately; a late response is ignored.
- Read with zero-wait bus: stall for 3 cycles (IDLE, REQ, RESP); `rdata` valid in the DONE cycle and held until the next read completes.
- Write with zero-wait bus: stall for 2 cycles (IDLE, REQ).
- Misaligned/illegal: stall for 1 cycle (IDLE), then DONE.
- `bus_addr`/`bus_wdata`/`bus_wstrb` come from capture registers and stay stable throughout REQ.

## Configuration
- `MCMEM_MISALIGN_CHECK_EN` defined:
  - Half accesses with addr[0]=1 and word/fetch accesses with addr[1:0]≠0 skip the bus.
  - They go IDLE→DONE, pulse `err_misaligned` and leave `rdata` unchanged.
- Undefined:
  - No check; `err_misaligned` is tied to 0.
  - Low address bits select lanes only: word accesses ignore addr[1:0], half accesses ignore addr[0].

## Structure
- Shared definitions package holds:
  - `mcmem_state_t` (IDLE/REQ/RESP/DONE).
  - funct3 constants `F3_LB`..`F3_LHU`, `F3_SB`/`F3_SH`/`F3_SW`.
- One sub-module, `mcmem_load_align`: combinational lane select plus sign/zero extension from (rdata word, addr[1:0], funct3, fetch).
- Store strobe/replication stays inline.

## Test plan
- Fetch of 0x100 with bus_rdata=0x00500093 and zero wait → stall for 3 cycles, rdata=0x00500093, rdata_valid pulse in DONE.
- LB at 0x203, word 0x80FF1234 → bus_addr=0x200, rdata=0xFFFFFF80; LBU at the same address → 0x00000080.
- SH at 0x106 with wdata=0x0000BEEF → bus_wstrb=1100, bus_wdata=0xBEEFBEEF, bus_we=1, stall for 2 cycles.
- bus_ready held low for 5 cycles → bus_valid and all bus fields stable for 5 cycles, stall for 7 cycles.
- bus_ready never asserted with MAX_WAIT=64 → err_timeout pulse after 64 bus cycles, rdata=0.
- LW at 0x102 with the macro defined → no bus_valid, err_misaligned pulse; reset_n low during RESP → bus_valid=0 at once, state IDLE, later rsp ignored.

Source files
------------

// File: rtl/mcmem_bridge_pkg.sv
// mcmem_bridge_pkg
// Shared definitions for the multicycle-core memory bridge:
//   - mcmem_state_t : bridge FSM states (IDLE/REQ/RESP/DONE)
//   - F3_*          : load/store funct3 encodings (instr[14:12])
//   - is_misaligned : natural-alignment test used when the optional
//                     MCMEM_MISALIGN_CHECK_EN build is selected
package mcmem_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } mcmem_state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // funct3[1:0] carries the access size for both loads and stores
  // (00 byte, 01 half, 1x word); fetches are always word-sized.
  function automatic logic is_misaligned(input logic [1:0] addr_lo,
                                         input logic [2:0] funct3,
                                         input logic       fetch);
    logic mis;
    if (fetch)
      mis = (addr_lo != 2'b00);
    else if (funct3[1:0] == 2'b00)
      mis = 1'b0;
    else if (funct3[1:0] == 2'b01)
      mis = addr_lo[0];
    else
      mis = (addr_lo != 2'b00);
    return mis;
  endfunction

endpackage

// File: rtl/mcmem_load_align.sv
// mcmem_load_align
// Combinational load lane select and sign/zero extension.
// Ports:
//   i_word    : raw 32-bit bus read word
//   i_addr_lo : byte address bits [1:0] of the access
//   i_funct3  : load funct3 (LB/LH/LW/LBU/LHU; 011/110/111 act as LW)
//   i_fetch   : instruction fetch, forces an unsigned word access
//   o_data    : aligned and extended load result
module mcmem_load_align
  import mcmem_bridge_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_addr_lo,
  input  logic [2:0]  i_funct3,
  input  logic        i_fetch,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_word[7:0];
    case (i_addr_lo)
      2'd0: w_byte = i_word[7:0];
      2'd1: w_byte = i_word[15:8];
      2'd2: w_byte = i_word[23:16];
      2'd3: w_byte = i_word[31:24];
      default: w_byte = i_word[7:0];
    endcase

    // Half lane uses addr[1] only; addr[0] never shifts the data.
    w_half = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];

    o_data = i_word;
    if (!i_fetch) begin
      case (i_funct3)
        F3_LB:   o_data = {{24{w_byte[7]}}, w_byte};
        F3_LBU:  o_data = {24'd0, w_byte};
        F3_LH:   o_data = {{16{w_half[15]}}, w_half};
        F3_LHU:  o_data = {16'd0, w_half};
        default: o_data = i_word;
      endcase
    end
  end

endmodule

// File: rtl/mcmem_bridge.sv
// mcmem_bridge
// Memory-side stage of the multicycle core. Turns the control FSM's
// MemRead/MemWrite strobes into one valid/ready bus transaction, lane-aligns
// stores, aligns/extends loads and holds the core with `stall` while busy.
// Optional build macro: MCMEM_MISALIGN_CHECK_EN (misaligned half/word/fetch
// accesses skip the bus and pulse err_misaligned; otherwise the low address
// bits only select lanes and err_misaligned is tied low).
// Ports:
//   clk, reset_n           : clock, asynchronous active-low reset
//   req_read/req_write     : memory strobes from the control FSM
//   req_is_fetch           : IorD=0, instruction fetch
//   req_addr/req_wdata     : byte address, unshifted store data
//   req_funct3             : instr[14:12]
//   stall                  : hold control FSM and datapath write-enables
//   rdata/rdata_valid      : registered load/fetch result and its DONE pulse
//   err_misaligned         : DONE pulse, access rejected as misaligned
//   err_timeout            : DONE pulse, bus did not answer in MAX_WAIT cycles
//   bus_valid/bus_ready    : request handshake
//   bus_we/bus_addr/bus_wdata/bus_wstrb : request fields (word address)
//   bus_rsp_valid/bus_rdata: read response
module mcmem_bridge
  import mcmem_bridge_pkg::*;
#(
  parameter int MAX_WAIT = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_read,
  input  logic        req_write,
  input  logic        req_is_fetch,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        err_misaligned,
  output logic        err_timeout,
  output logic        bus_valid,
  input  logic        bus_ready,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  input  logic        bus_rsp_valid,
  input  logic [31:0] bus_rdata
);

  localparam logic [7:0] LP_CNT_LAST = 8'(MAX_WAIT - 1);

  mcmem_state_t r_state;
  logic [31:0]  r_addr;
  logic [2:0]   r_funct3;
  logic         r_we;
  logic         r_fetch;
  logic [3:0]   r_wstrb;
  logic [31:0]  r_bus_wdata;
  logic [31:0]  r_rdata;
  logic [7:0]   r_cnt;
  logic         r_rdata_valid;
  logic         r_err_mis;
  logic         r_err_to;

  logic         w_req;
  logic         w_mis;
  logic         w_timeout;
  logic [3:0]   w_wstrb;
  logic [31:0]  w_wdata_rep;
  logic [31:0]  w_load_data;

  assign w_req     = req_read | req_write;
  assign w_timeout = (r_cnt == LP_CNT_LAST);

`ifdef MCMEM_MISALIGN_CHECK_EN
  assign w_mis = is_misaligned(req_addr[1:0], req_funct3, req_is_fetch);
`else
  assign w_mis = 1'b0;
`endif

  // Store lane strobes and replication are computed at capture time so the
  // bus fields come straight from registers for the whole REQ phase.
  always_comb begin
    w_wstrb     = 4'b1111;
    w_wdata_rep = req_wdata;
    case (req_funct3[1:0])
      2'b00: begin
        w_wstrb     = 4'b0001 << req_addr[1:0];
        w_wdata_rep = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        w_wstrb     = 4'b0011 << {req_addr[1], 1'b0};
        w_wdata_rep = {2{req_wdata[15:0]}};
      end
      default: begin
        w_wstrb     = 4'b1111;
        w_wdata_rep = req_wdata;
      end
    endcase
  end

  mcmem_load_align u_load_align (
    .i_word    (bus_rdata),
    .i_addr_lo (r_addr[1:0]),
    .i_funct3  (r_funct3),
    .i_fetch   (r_fetch),
    .o_data    (w_load_data)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_addr        <= '0;
      r_funct3      <= '0;
      r_we          <= 1'b0;
      r_fetch       <= 1'b0;
      r_wstrb       <= '0;
      r_bus_wdata   <= '0;
      r_rdata       <= '0;
      r_cnt         <= '0;
      r_rdata_valid <= 1'b0;
      r_err_mis     <= 1'b0;
      r_err_to      <= 1'b0;
    end else begin
      // DONE pulses are set only on the transition into DONE.
      r_rdata_valid <= 1'b0;
      r_err_mis     <= 1'b0;
      r_err_to      <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_req) begin
            r_addr      <= req_addr;
            r_funct3    <= req_funct3;
            r_we        <= req_write;
            r_fetch     <= req_is_fetch;
            r_wstrb     <= req_write ? w_wstrb : 4'b0000;
            r_bus_wdata <= w_wdata_rep;
            r_cnt       <= '0;
            if (req_read && req_write) begin
              // Illegal combination: complete without touching the bus.
              r_state <= DONE;
            end else if (w_mis) begin
              r_state   <= DONE;
              r_err_mis <= 1'b1;
            end else begin
              r_state <= REQ;
            end
          end
        end
        REQ: begin
          r_cnt <= r_cnt + 8'd1;
          if (bus_ready) begin
            // Writes are posted: no response phase.
            r_state <= r_we ? DONE : RESP;
          end else if (w_timeout) begin
            r_state  <= DONE;
            r_err_to <= 1'b1;
            r_rdata  <= '0;
          end
        end
        RESP: begin
          r_cnt <= r_cnt + 8'd1;
          if (bus_rsp_valid) begin
            r_rdata       <= w_load_data;
            r_rdata_valid <= 1'b1;
            r_state       <= DONE;
          end else if (w_timeout) begin
            r_state  <= DONE;
            r_err_to <= 1'b1;
            r_rdata  <= '0;
          end
        end
        DONE: begin
          // Strobes seen here still belong to the completing access.
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Combinational so the control FSM holds from the very first request cycle.
  assign stall = reset_n & (((r_state == IDLE) & w_req) |
                            (r_state == REQ) | (r_state == RESP));

  assign bus_valid      = (r_state == REQ);
  assign bus_we         = r_we;
  assign bus_addr       = {r_addr[31:2], 2'b00};
  assign bus_wdata      = r_bus_wdata;
  assign bus_wstrb      = r_wstrb;
  assign rdata          = r_rdata;
  assign rdata_valid    = r_rdata_valid;
  assign err_misaligned = r_err_mis;
  assign err_timeout    = r_err_to;

endmodule

// File: tb/tb_mcmem_bridge.sv
// tb_mcmem_bridge
// Directed bench for mcmem_bridge. Each access pushes its expected outcome
// onto a scoreboard queue; the entry is popped and compared when the bridge
// reaches DONE. The bench also plays the bus slave (ready delay, response).
// Honors MCMEM_MISALIGN_CHECK_EN the same way the design does.
module tb_mcmem_bridge;

  localparam int MAX_WAIT = 64;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_read, req_write, req_is_fetch;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_funct3;
  logic        stall;
  logic [31:0] rdata;
  logic        rdata_valid, err_misaligned, err_timeout;
  logic        bus_valid, bus_ready, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_rsp_valid;
  logic [31:0] bus_rdata;

  always #5 clk = ~clk;

  mcmem_bridge #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .req_read       (req_read),
    .req_write      (req_write),
    .req_is_fetch   (req_is_fetch),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .req_funct3     (req_funct3),
    .stall          (stall),
    .rdata          (rdata),
    .rdata_valid    (rdata_valid),
    .err_misaligned (err_misaligned),
    .err_timeout    (err_timeout),
    .bus_valid      (bus_valid),
    .bus_ready      (bus_ready),
    .bus_we         (bus_we),
    .bus_addr       (bus_addr),
    .bus_wdata      (bus_wdata),
    .bus_wstrb      (bus_wstrb),
    .bus_rsp_valid  (bus_rsp_valid),
    .bus_rdata      (bus_rdata)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        rvalid;
    logic        emis;
    logic        eto;
    int          stalls;
    int          valids;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] hold  = 32'd0;   // model of the held rdata register

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_load(input logic [31:0] word, input logic [1:0] a,
                                             input logic [2:0] f3, input logic fetch);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[8*int'(a) +: 8];
    h = word[16*int'(a[1]) +: 16];
    if (fetch) return word;
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'd0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'd0, h};
      default: return word;
    endcase
  endfunction

  function automatic logic [3:0] model_strb(input logic [1:0] a, input logic [2:0] f3);
    logic [3:0] s;
    for (int i = 0; i < 4; i++) begin
      if (f3 == 3'b000)      s[i] = (i == int'(a));
      else if (f3 == 3'b001) s[i] = ((i / 2) == int'(a[1]));
      else                   s[i] = 1'b1;
    end
    return s;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [31:0] w, input logic [2:0] f3);
    if (f3 == 3'b000) return {w[7:0], w[7:0], w[7:0], w[7:0]};
    if (f3 == 3'b001) return {w[15:0], w[15:0]};
    return w;
  endfunction

  function automatic logic model_mis(input logic [1:0] a, input logic [2:0] f3, input logic fetch);
`ifdef MCMEM_MISALIGN_CHECK_EN
    if (fetch) return a != 2'b00;
    if (f3[1:0] == 2'b00) return 1'b0;
    if (f3[1:0] == 2'b01) return a[0];
    return a != 2'b00;
`else
    return 1'b0;
`endif
  endfunction

  // One access; wait_n = cycles bus_ready stays low in REQ, -1 = never ready.
  task automatic run(input string name, input logic rd, input logic wr, input logic fetch,
                     input logic [31:0] addr, input logic [31:0] wdata, input logic [2:0] f3,
                     input logic [31:0] word, input int wait_n);
    exp_t        e, got;
    logic        illegal, mis, use_bus;
    logic [31:0] exp_baddr, exp_wdata;
    logic [3:0]  exp_strb;
    int          stalls, valids;
    logic        done;

    illegal  = rd & wr;
    mis      = !illegal && model_mis(addr[1:0], f3, fetch);
    use_bus  = !illegal && !mis;
    e.emis   = mis;
    e.eto    = use_bus && (wait_n < 0);
    e.rvalid = use_bus && rd && (wait_n >= 0);
    if (e.eto)         hold = 32'd0;
    else if (e.rvalid) hold = model_load(word, addr[1:0], f3, fetch);
    e.rdata  = hold;
    e.stalls = !use_bus ? 1 : e.eto ? 1 + MAX_WAIT : 1 + (wait_n + 1) + (rd ? 1 : 0);
    e.valids = !use_bus ? 0 : e.eto ? MAX_WAIT : wait_n + 1;
    sb.push_back(e);
    exp_baddr = {addr[31:2], 2'b00};
    exp_strb  = model_strb(addr[1:0], f3);
    exp_wdata = model_wdata(wdata, f3);

    @(negedge clk);
    req_read = rd; req_write = wr; req_is_fetch = fetch;
    req_addr = addr; req_wdata = wdata; req_funct3 = f3;
    stalls = 0; valids = 0; done = 1'b0;
    for (int cyc = 0; cyc < 300 && !done; cyc++) begin
      if (cyc > 0) begin
        @(negedge clk);
        req_read = 1'b0; req_write = 1'b0;
      end
      #1;
      if (!stall && cyc > 0) begin
        done = 1'b1;
      end else begin
        if (stall) stalls++;
        bus_ready = 1'b0; bus_rsp_valid = 1'b0;
        if (bus_valid) begin
          valids++;
          chk({name, ".bus_addr"}, bus_addr, exp_baddr);
          chk({name, ".bus_we"}, 32'(bus_we), 32'(wr));
          if (wr) begin
            chk({name, ".bus_wstrb"}, 32'(bus_wstrb), 32'(exp_strb));
            chk({name, ".bus_wdata"}, bus_wdata, exp_wdata);
          end
          // A stray response during REQ must be ignored.
          bus_rsp_valid = 1'b1; bus_rdata = ~word;
          if (wait_n >= 0 && valids > wait_n) bus_ready = 1'b1;
        end else if (stall && valids > 0) begin
          bus_rsp_valid = 1'b1; bus_rdata = word;
        end
      end
    end
    bus_ready = 1'b0; bus_rsp_valid = 1'b0;
    chk({name, ".completed"}, 32'(done), 32'd1);

    got = sb.pop_front();
    chk({name, ".rdata"}, rdata, got.rdata);
    chk({name, ".rdata_valid"}, 32'(rdata_valid), 32'(got.rvalid));
    chk({name, ".err_misaligned"}, 32'(err_misaligned), 32'(got.emis));
    chk({name, ".err_timeout"}, 32'(err_timeout), 32'(got.eto));
    chk({name, ".stall_cycles"}, 32'(stalls), 32'(got.stalls));
    chk({name, ".valid_cycles"}, 32'(valids), 32'(got.valids));
    $display("txn %s rd=%0b wr=%0b addr=%h rdata=%h stalls=%0d", name, rd, wr, addr, rdata, stalls);

    @(negedge clk); #1;
    chk({name, ".pulses_clear"}, {29'd0, rdata_valid, err_misaligned, err_timeout}, 32'd0);
  endtask

  initial begin
    reset_n = 1'b0;
    req_read = 1'b1; req_write = 1'b0; req_is_fetch = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; req_funct3 = 3'b010;
    bus_ready = 1'b1; bus_rsp_valid = 1'b1; bus_rdata = 32'hFFFF_FFFF;

    // Reset state, with strobes and bus inputs active during reset.
    repeat (3) @(negedge clk);
    #1;
    chk("rst.stall", 32'(stall), 32'd0);
    chk("rst.bus_valid", 32'(bus_valid), 32'd0);
    chk("rst.bus_we", 32'(bus_we), 32'd0);
    chk("rst.bus_wstrb", 32'(bus_wstrb), 32'd0);
    chk("rst.rdata", rdata, 32'd0);
    chk("rst.pulses", {29'd0, rdata_valid, err_misaligned, err_timeout}, 32'd0);
    req_read = 1'b0; bus_ready = 1'b0; bus_rsp_valid = 1'b0;
    reset_n = 1'b1;

    run("fetch",   1, 0, 1, 32'h0000_0100, 32'h0,         3'b000, 32'h0050_0093, 0);
    run("lb",      1, 0, 0, 32'h0000_0203, 32'h0,         3'b000, 32'h80FF_1234, 0);
    run("lbu",     1, 0, 0, 32'h0000_0203, 32'h0,         3'b100, 32'h80FF_1234, 0);
    run("lb_l1",   1, 0, 0, 32'h0000_0201, 32'h0,         3'b000, 32'h80FF_1234, 0);
    run("lh",      1, 0, 0, 32'h0000_0202, 32'h0,         3'b001, 32'h80FF_1234, 0);
    run("lhu",     1, 0, 0, 32'h0000_0200, 32'h0,         3'b101, 32'h80FF_9234, 0);
    run("sh",      0, 1, 0, 32'h0000_0106, 32'h0000_BEEF, 3'b001, 32'h0,         0);
    run("sb",      0, 1, 0, 32'h0000_0101, 32'h0000_00AB, 3'b000, 32'h0,         0);
    run("sw_wait", 0, 1, 0, 32'h0000_010C, 32'hCAFE_F00D, 3'b010, 32'h0,         5);
    run("lw_wait", 1, 0, 0, 32'h0000_0110, 32'h0,         3'b011, 32'h1234_5678, 2);
    run("timeout", 1, 0, 0, 32'h0000_0120, 32'h0,         3'b010, 32'h5555_AAAA, -1);
    run("lw",      1, 0, 0, 32'h0000_0124, 32'h0,         3'b010, 32'hA5A5_0F0F, 0);
    run("illegal", 1, 1, 0, 32'h0000_0130, 32'h1111_2222, 3'b010, 32'h3333_4444, 0);
    run("lw_mis",  1, 0, 0, 32'h0000_0102, 32'h0,         3'b010, 32'h7654_3210, 0);
    run("sh_odd",  0, 1, 0, 32'h0000_0105, 32'h0000_1234, 3'b001, 32'h0,         0);

    // Reset asserted during REQ drops bus_valid immediately.
    @(negedge clk);
    req_read = 1'b1; req_addr = 32'h0000_0300; req_funct3 = 3'b010; req_is_fetch = 1'b0;
    bus_ready = 1'b0;
    @(negedge clk);
    req_read = 1'b0;
    #1;
    chk("rstreq.bus_valid_before", 32'(bus_valid), 32'd1);
    reset_n = 1'b0;
    #1;
    hold = 32'd0;
    chk("rstreq.bus_valid", 32'(bus_valid), 32'd0);
    chk("rstreq.stall", 32'(stall), 32'd0);
    chk("rstreq.rdata", rdata, hold);
    @(negedge clk);
    reset_n = 1'b1;
    $display("txn rst_in_req bus_valid=%0b", bus_valid);

    // Reset asserted during RESP; a late response afterwards is ignored.
    run("lw_pre",  1, 0, 0, 32'h0000_0400, 32'h0,         3'b010, 32'h1111_1111, 0);
    @(negedge clk);
    req_read = 1'b1; req_addr = 32'h0000_0500; req_funct3 = 3'b010;
    @(negedge clk);
    req_read = 1'b0;
    #1;
    bus_ready = 1'b1;
    @(negedge clk);
    bus_ready = 1'b0;
    #1;
    chk("rstresp.in_resp_stall", 32'(stall), 32'd1);
    reset_n = 1'b0;
    #1;
    hold = 32'd0;
    chk("rstresp.stall", 32'(stall), 32'd0);
    chk("rstresp.rdata", rdata, hold);
    @(negedge clk);
    reset_n = 1'b1;
    bus_rsp_valid = 1'b1; bus_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("rstresp.late_rvalid", 32'(rdata_valid), 32'd0);
      chk("rstresp.late_rdata", rdata, hold);
      chk("rstresp.late_stall_valid", {30'd0, stall, bus_valid}, 32'd0);
    end
    bus_rsp_valid = 1'b0;
    $display("txn rst_in_resp rdata=%h", rdata);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
